i2c_slave: RTL

I2C_SLAVE -- requirements
Module: i2c_slave

---
 rtl/i2c_slave.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave.sv
// I2C target (slave) controller with a 7-bit address match.
// SCL and SDA are oversampled on clk. START, STOP and SCL edges are decoded from
// the synchronized copies. The block handles address, write and read phases,
// and drives SDA through an open-drain enable.

module i2c_slave #(
    parameter logic [6:0] SLV_ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rw,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX,
        RX_ACK,
        TX,
        TX_ACK,
        WAIT
    } state_t;

    // Synchronizer stages: meta -> sync, with prev kept for edge detection.
    logic scl_meta_q, scl_meta_d;
    logic scl_sync_q, scl_sync_d;
    logic scl_prev_q, scl_prev_d;
    logic sda_meta_q, sda_meta_d;
    logic sda_sync_q, sda_sync_d;
    logic sda_prev_q, sda_prev_d;

    // Protocol state.
    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_pend_q, rx_pend_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_load_q, tx_load_d;
    logic       ack_seen_q, ack_seen_d;

    // Decoded bus events.
    logic scl_rise;
    logic scl_fall;
    logic scl_steady_high;
    logic start_evt;
    logic stop_evt;

    // START and STOP are only recognized while SCL is stable high across both
    // samples. An SDA change that coincides with an SCL edge therefore decodes
    // as the SCL edge alone.
    always_comb begin
        scl_rise        = scl_sync_q & ~scl_prev_q;
        scl_fall        = ~scl_sync_q & scl_prev_q;
        scl_steady_high = scl_sync_q & scl_prev_q;
        start_evt       = scl_steady_high & ~sda_sync_q & sda_prev_q;
        stop_evt        = scl_steady_high & sda_sync_q & ~sda_prev_q;
    end

    // Next-state logic for the synchronizers and the protocol engine.
    always_comb begin
        scl_meta_d = i_scl;
        scl_sync_d = scl_meta_q;
        scl_prev_d = scl_sync_q;
        sda_meta_d = i_sda;
        sda_sync_d = sda_meta_q;
        sda_prev_d = sda_sync_q;

        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        sda_oe_d   = sda_oe_q;
        rw_d       = rw_q;
        busy_d     = busy_q;
        rx_data_d  = rx_data_q;
        rx_pend_d  = 1'b0;
        rx_valid_d = rx_pend_q;
        tx_load_d  = 1'b0;
        ack_seen_d = ack_seen_q;

        if (start_evt) begin
            state_d    = ADDR;
            bit_cnt_d  = 3'd7;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            ack_seen_d = 1'b0;
        end else if (stop_evt) begin
            state_d    = IDLE;
            bit_cnt_d  = 3'd7;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            ack_seen_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    sda_oe_d = 1'b0;
                end

                ADDR: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_sync_q};
                        if (bit_cnt_q == 3'd0) begin
                            bit_cnt_d = 3'd7;
                            if (shift_q[6:0] == SLV_ADDR) begin
                                rw_d    = sda_sync_q;
                                busy_d  = 1'b1;
                                state_d = ADDR_ACK;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = WAIT;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end
                end

                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else if (rw_q) begin
                            shift_d   = {tx_data[6:0], 1'b0};
                            sda_oe_d  = ~tx_data[7];
                            tx_load_d = 1'b1;
                            bit_cnt_d = 3'd7;
                            state_d   = TX;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd7;
                            state_d   = RX;
                        end
                    end
                end

                RX: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_sync_q};
                        if (bit_cnt_q == 3'd0) begin
                            rx_data_d = {shift_q[6:0], sda_sync_q};
                            rx_pend_d = 1'b1;
                            bit_cnt_d = 3'd7;
                            state_d   = RX_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end
                end

                RX_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd7;
                            state_d   = RX;
                        end
                    end
                end

                TX: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            sda_oe_d   = 1'b0;
                            bit_cnt_d  = 3'd7;
                            ack_seen_d = 1'b0;
                            state_d    = TX_ACK;
                        end else begin
                            sda_oe_d  = ~shift_q[7];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end
                end

                TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_sync_q) begin
                            sda_oe_d = 1'b0;
                            busy_d   = 1'b0;
                            state_d  = WAIT;
                        end else begin
                            ack_seen_d = 1'b1;
                        end
                    end else if (scl_fall && ack_seen_q) begin
                        shift_d    = {tx_data[6:0], 1'b0};
                        sda_oe_d   = ~tx_data[7];
                        tx_load_d  = 1'b1;
                        bit_cnt_d  = 3'd7;
                        ack_seen_d = 1'b0;
                        state_d    = TX;
                    end
                end

                WAIT: begin
                    sda_oe_d = 1'b0;
                end

                default: begin
                    sda_oe_d = 1'b0;
                    state_d  = IDLE;
                end
            endcase
        end
    end

    // Register all state. A synchronous reset parks the engine in IDLE with SDA released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd7;
            shift_q    <= 8'h00;
            sda_oe_q   <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_pend_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_load_q  <= 1'b0;
            ack_seen_q <= 1'b0;
        end else begin
            scl_meta_q <= scl_meta_d;
            scl_sync_q <= scl_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_meta_q <= sda_meta_d;
            sda_sync_q <= sda_sync_d;
            sda_prev_q <= sda_prev_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            sda_oe_q   <= sda_oe_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
            rx_data_q  <= rx_data_d;
            rx_pend_q  <= rx_pend_d;
            rx_valid_q <= rx_valid_d;
            tx_load_q  <= tx_load_d;
            ack_seen_q <= ack_seen_d;
        end
    end

    // Every output comes straight from a flop.
    always_comb begin
        o_sda_oe = sda_oe_q;
        tx_load  = tx_load_q;
        rx_data  = rx_data_q;
        rx_valid = rx_valid_q;
        rw       = rw_q;
        busy     = busy_q;
    end

endmodule
